conv_stream_tx: RTL and testbench
=================================

CONV_STREAM_TX -- requirements
Module: conv_stream_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 16, pixel word width.
REQ-002 Parameter KERNEL_WIDTH, default 16, kernel coefficient width; one kernel word is 9*KERNEL_WIDTH = 144 bits.
REQ-003 Parameter ADDR_WIDTH, default 25, pixel memory address width.
REQ-004 Port clk, input, 1, single clock; all logic on posedge.
REQ-005 Port Reset, input, 1; asynchronous, active-high reset.
REQ-006 Port start, input, 1; single-cycle request to begin one transfer.
REQ-007 Port CHANNEL_SIZE, input, 9; input channel count, sampled at accepted start.
REQ-008 Port IMAGE_SIZE, input, 8; image width = height, sampled at accepted start.
REQ-009 Port kernel_rd_en, output, 1; kernel memory read strobe.
REQ-010 Port kernel_addr, output, 9; kernel memory address.
REQ-011 Port kernel_rdata, input, 144; valid exactly 1 cycle after kernel_rd_en.
REQ-012 Port pixel_rd_en, output, 1; pixel memory read strobe.
REQ-013 Port pixel_addr, output, ADDR_WIDTH; pixel memory address.
REQ-014 Port pixel_rdata, input, DATA_WIDTH; valid exactly 1 cycle after pixel_rd_en.
REQ-015 Port m_axis_tdata, output, 256; stream payload.
REQ-016 Port m_axis_tvalid, output, 1.
REQ-017 Port m_axis_tlast, output, 1.
REQ-018 Port m_axis_tready, input, 1.
REQ-019 Port slave_select, output, 1; 0 = kernel phase, 1 = pixel phase (drives consumer's tready mux).
REQ-020 Port busy, output, 1; high from accepted start until done.
REQ-021 Port done, output, 1; single-cycle pulse at transfer completion.

Function
REQ-022 FSM states IDLE, KERNEL, PIXEL, DRAIN; IDLE->KERNEL on start; KERNEL->PIXEL after last kernel read issued; PIXEL->DRAIN after last pixel read issued; DRAIN->IDLE when last beat handshaken, asserting done that cycle.
REQ-023 start accepted only in IDLE; start while busy ignored, sizes not resampled.
REQ-024 start with CHANNEL_SIZE==0 or IMAGE_SIZE==0: no beats, no reads, done pulses the next cycle, busy stays 0.
REQ-025 KERNEL phase: CHANNEL_SIZE beats, addresses 0..CHANNEL_SIZE-1 ascending; tdata = {112'b0, kernel_rdata}; tlast on the final kernel beat only.
REQ-026 PIXEL phase: CHANNEL_SIZE*IMAGE_SIZE*IMAGE_SIZE beats, pixel_addr linear 0 upward, +1 per read; tdata = {(256-DATA_WIDTH)'b0, pixel_rdata}; tlast on last pixel of every image row (every IMAGE_SIZE beats).
REQ-027 Row/column/channel counters: column wraps at IMAGE_SIZE-1 to 0, incrementing row; row wraps at IMAGE_SIZE-1 incrementing channel; final beat when all three terminal.
REQ-028 slave_select changes 0->1 only after the last kernel beat is handshaken; never while a kernel beat is pending.
REQ-029 Output holds a 2-entry buffer; a read is issued only if buffered beats plus in-flight reads < 2, so no memory data is ever dropped.
REQ-030 While tvalid=1 and tready=0, tdata and tlast held stable; tvalid never deasserts without handshake.
REQ-031 With tready held 1, sustained throughput is 1 beat/cycle, including across the kernel-to-pixel boundary and row boundaries.
REQ-032 First tvalid asserted 2 cycles after the accepted start cycle.
REQ-033 kernel_rd_en and pixel_rd_en never asserted in the same cycle.

Reset
REQ-034 Reset asserted: state IDLE, all counters 0, buffer emptied; m_axis_tvalid, m_axis_tlast, kernel_rd_en, pixel_rd_en, busy, done, slave_select = 0; addresses and tdata = 0.
REQ-035 Reset mid-transfer aborts immediately without done; next start after release begins a fresh transfer at address 0.

Verification
REQ-036 CHANNEL_SIZE=2, IMAGE_SIZE=3, tready=1 -> 2 kernel beats (tlast on 2nd), then 18 pixel beats with tlast on beats 3,6,...,18, addr 0..17, done one cycle after beat 20.
REQ-037 Same config, tready random 50% -> identical beat sequence and data, no duplicated or lost beat, tdata stable while stalled.
REQ-038 tready=0 for 10 cycles after start -> exactly 2 reads issued, tvalid held with beat 0, then resumes in order.
REQ-039 CHANNEL_SIZE=0 -> no reads, no tvalid, done pulse one cycle after start; start during busy -> ignored.
REQ-040 Reset asserted during pixel beat 7 -> all outputs 0 same cycle; new start with CHANNEL_SIZE=1, IMAGE_SIZE=1 -> 1 kernel beat, 1 pixel beat at addr 0, both tlast.

Source files
------------

// File: rtl/conv_stream_tx.sv
// Streams one kernel block, then one pixel volume, from two read-latency-1 memories
// onto a single AXI-stream master port, using a 2-entry output buffer.
module conv_stream_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_WIDTH = 16,
  parameter int ADDR_WIDTH   = 25
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      start,
  input  logic [8:0]                CHANNEL_SIZE,
  input  logic [7:0]                IMAGE_SIZE,
  output logic                      kernel_rd_en,
  output logic [8:0]                kernel_addr,
  input  logic [9*KERNEL_WIDTH-1:0] kernel_rdata,
  output logic                      pixel_rd_en,
  output logic [ADDR_WIDTH-1:0]     pixel_addr,
  input  logic [DATA_WIDTH-1:0]     pixel_rdata,
  output logic [255:0]              m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      slave_select,
  output logic                      busy,
  output logic                      done
);

  localparam int KW_BITS = 9 * KERNEL_WIDTH;

  typedef enum logic [1:0] {IDLE, KERNEL, PIXEL, DRAIN} state_t;

  state_t                  state, state_next;
  logic [8:0]              ch_q;
  logic [7:0]              img_q;
  logic [8:0]              kcnt;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [7:0]              col, row;
  logic [8:0]              chn;

  logic                    rd_valid_q, rd_kernel_q, rd_last_q, rd_kend_q, rd_fin_q;
  logic                    rd_last, rd_kend, rd_fin;

  logic [255:0]            buf_data [2];
  logic                    buf_last [2];
  logic                    buf_kend [2];
  logic                    buf_fin  [2];
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              count;

  logic                    pop, credit, accept, zero_size;
  logic                    col_end, row_end, ch_end;
  logic [2:0]              occupancy;

  assign pop       = (count != 2'd0) && m_axis_tready;
  // A slot freed by this cycle's pop can be reused by this cycle's read.
  assign occupancy = {1'b0, count} + {2'b0, rd_valid_q} - {2'b0, pop};
  assign credit    = occupancy < 3'd2;
  assign accept    = (state == IDLE) && start && !Reset;
  assign zero_size = (CHANNEL_SIZE == 9'd0) || (IMAGE_SIZE == 8'd0);
  assign col_end   = col == img_q - 8'd1;
  assign row_end   = row == img_q - 8'd1;
  assign ch_end    = chn == ch_q - 9'd1;

  always_comb begin
    state_next   = state;
    kernel_rd_en = 1'b0;
    pixel_rd_en  = 1'b0;
    rd_last      = 1'b0;
    rd_kend      = 1'b0;
    rd_fin       = 1'b0;
    case (state)
      IDLE: begin
        // The first kernel read goes out in the start cycle to reach tvalid two cycles later.
        if (accept && !zero_size) begin
          kernel_rd_en = 1'b1;
          rd_kend      = CHANNEL_SIZE == 9'd1;
          rd_last      = rd_kend;
          state_next   = rd_kend ? PIXEL : KERNEL;
        end
      end
      KERNEL: begin
        if (credit) begin
          kernel_rd_en = 1'b1;
          rd_kend      = kcnt == ch_q - 9'd1;
          rd_last      = rd_kend;
          if (rd_kend) state_next = PIXEL;
        end
      end
      PIXEL: begin
        if (credit) begin
          pixel_rd_en = 1'b1;
          rd_last     = col_end;
          rd_fin      = col_end && row_end && ch_end;
          if (rd_fin) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && buf_fin[rd_ptr]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ch_q  <= '0;
      img_q <= '0;
      kcnt  <= '0;
      paddr <= '0;
      col   <= '0;
      row   <= '0;
      chn   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        ch_q  <= CHANNEL_SIZE;
        img_q <= IMAGE_SIZE;
      end
      if (kernel_rd_en) kcnt <= rd_kend ? 9'd0 : kcnt + 9'd1;
      if (pixel_rd_en) begin
        if (rd_fin) begin
          paddr <= '0;
          col   <= '0;
          row   <= '0;
          chn   <= '0;
        end else begin
          paddr <= paddr + 1'b1;
          col   <= col_end ? 8'd0 : col + 8'd1;
          if (col_end) begin
            row <= row_end ? 8'd0 : row + 8'd1;
            if (row_end) chn <= chn + 9'd1;
          end
        end
      end
    end
  end

  // Memory data lands one cycle after the strobe and is written straight into the buffer.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rd_valid_q  <= 1'b0;
      rd_kernel_q <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_kend_q   <= 1'b0;
      rd_fin_q    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
        buf_kend[i] <= 1'b0;
        buf_fin[i]  <= 1'b0;
      end
    end else begin
      rd_valid_q  <= kernel_rd_en || pixel_rd_en;
      rd_kernel_q <= kernel_rd_en;
      rd_last_q   <= rd_last;
      rd_kend_q   <= rd_kend;
      rd_fin_q    <= rd_fin;
      if (rd_valid_q) begin
        buf_data[wr_ptr] <= rd_kernel_q ? {{(256-KW_BITS){1'b0}}, kernel_rdata}
                                        : {{(256-DATA_WIDTH){1'b0}}, pixel_rdata};
        buf_last[wr_ptr] <= rd_last_q;
        buf_kend[wr_ptr] <= rd_kend_q;
        buf_fin[wr_ptr]  <= rd_fin_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, rd_valid_q} - {1'b0, pop};
    end
  end

  // slave_select flips only once the last kernel beat has actually left.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      slave_select <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (pop && buf_fin[rd_ptr])       slave_select <= 1'b0;
      else if (pop && buf_kend[rd_ptr]) slave_select <= 1'b1;
      done <= (pop && buf_fin[rd_ptr]) || (accept && zero_size);
    end
  end

  assign m_axis_tvalid = count != 2'd0;
  assign m_axis_tdata  = m_axis_tvalid ? buf_data[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && buf_last[rd_ptr];
  assign busy          = state != IDLE;
  assign kernel_addr   = kcnt;
  assign pixel_addr    = paddr;

endmodule

// File: tb/tb_conv_stream_tx.sv
// Directed bench for conv_stream_tx: memory models return address-tagged words so
// every beat's payload, tlast and phase can be predicted from its index.
module tb_conv_stream_tx;

  localparam int AW = 25;

  logic         clk = 1'b0;
  logic         Reset;
  logic         start;
  logic [8:0]   CHANNEL_SIZE;
  logic [7:0]   IMAGE_SIZE;
  logic         kernel_rd_en;
  logic [8:0]   kernel_addr;
  logic [143:0] kernel_rdata;
  logic         pixel_rd_en;
  logic [AW-1:0] pixel_addr;
  logic [15:0]  pixel_rdata;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready;
  logic         slave_select;
  logic         busy;
  logic         done;

  int check_count = 0;
  int pass_count  = 0;

  conv_stream_tx #(.DATA_WIDTH(16), .KERNEL_WIDTH(16), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .Reset(Reset), .start(start),
    .CHANNEL_SIZE(CHANNEL_SIZE), .IMAGE_SIZE(IMAGE_SIZE),
    .kernel_rd_en(kernel_rd_en), .kernel_addr(kernel_addr), .kernel_rdata(kernel_rdata),
    .pixel_rd_en(pixel_rd_en), .pixel_addr(pixel_addr), .pixel_rdata(pixel_rdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .slave_select(slave_select), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Latency-1 memories whose words encode their own address.
  always @(posedge clk) begin
    if (kernel_rd_en) kernel_rdata <= {16'hBEEF, 119'd0, kernel_addr};
    if (pixel_rd_en)  pixel_rdata  <= {4'h5, pixel_addr[11:0]};
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    check_count++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    else
      pass_count++;
  endtask

  function automatic void expectBeat(input int i, input int ch, input int img,
                                     output logic [255:0] d, output logic l, output logic s);
    int j;
    if (i < ch) begin
      d = {112'd0, 16'hBEEF, 119'd0, 9'(i)};
      l = (i == ch - 1);
      s = 1'b0;
    end else begin
      j = i - ch;
      d = {240'd0, 4'h5, 12'(j)};
      l = ((j % img) == img - 1);
      s = 1'b1;
    end
  endfunction

  function automatic logic readyFor(input int cyc, input int stall, input int random_ready);
    if (cyc < stall) return 1'b0;
    if (random_ready != 0) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // One full transfer; start cycle is cycle 0, outputs sampled on the falling edge.
  task automatic applyStimulus(input int ch, input int img, input int random_ready,
                               input int stall, input bit extra_start);
    int total, budget, beat, cyc, k_reads, p_reads, first_valid;
    int addr_err, both_err, hold_err, done_err;
    logic prev_stall;
    logic [255:0] prev_data, exp_data;
    logic prev_last, exp_last, exp_sel;
    bit finished;
    total = ch + ch * img * img;
    budget = total * 20 + 60;
    beat = 0; cyc = 0; k_reads = 0; p_reads = 0; first_valid = -1;
    addr_err = 0; both_err = 0; hold_err = 0; done_err = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; finished = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    CHANNEL_SIZE = 9'(ch);
    IMAGE_SIZE = 8'(img);
    m_axis_tready = readyFor(0, stall, random_ready);
    while (!finished && cyc < budget) begin
      @(negedge clk);
      if (kernel_rd_en && pixel_rd_en) both_err++;
      if (kernel_rd_en) begin
        if (kernel_addr != 9'(k_reads)) addr_err++;
        k_reads++;
      end
      if (pixel_rd_en) begin
        if (pixel_addr != AW'(p_reads)) addr_err++;
        p_reads++;
      end
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
        hold_err++;
      if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (done) done_err++;
      if (stall > 0 && cyc == stall - 1) begin
        expectBeat(0, ch, img, exp_data, exp_last, exp_sel);
        checkOutput("stall_reads", 256'(k_reads + p_reads), 256'd2);
        checkOutput("stall_tvalid", 256'(m_axis_tvalid), 256'd1);
        checkOutput("stall_tdata", m_axis_tdata, exp_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        expectBeat(beat, ch, img, exp_data, exp_last, exp_sel);
        checkOutput($sformatf("beat%0d_tdata", beat), m_axis_tdata, exp_data);
        checkOutput($sformatf("beat%0d_tlast", beat), 256'(m_axis_tlast), 256'(exp_last));
        checkOutput($sformatf("beat%0d_select", beat), 256'(slave_select), 256'(exp_sel));
        beat++;
        if (beat == total) finished = 1'b1;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      @(posedge clk); #1;
      cyc++;
      start = extra_start && (cyc == 5);
      CHANNEL_SIZE = 9'd1;
      IMAGE_SIZE = 8'd1;
      m_axis_tready = readyFor(cyc, stall, random_ready);
    end
    start = 1'b0;
    checkOutput("beats_seen", 256'(beat), 256'(total));
    @(negedge clk);
    checkOutput("done_after_last", 256'(done), 256'd1);
    checkOutput("busy_after_last", 256'(busy), 256'd0);
    checkOutput("tvalid_after_last", 256'(m_axis_tvalid), 256'd0);
    checkOutput("first_valid_cycle", 256'(first_valid), 256'd2);
    checkOutput("kernel_reads", 256'(k_reads), 256'(ch));
    checkOutput("pixel_reads", 256'(p_reads), 256'(ch * img * img));
    checkOutput("addr_order_errors", 256'(addr_err), 256'd0);
    checkOutput("both_rd_en_errors", 256'(both_err), 256'd0);
    checkOutput("hold_errors", 256'(hold_err), 256'd0);
    checkOutput("early_done_count", 256'(done_err), 256'd0);
    @(negedge clk);
    checkOutput("done_single_pulse", 256'(done), 256'd0);
  endtask

  task automatic zeroCase(input int ch, input int img);
    @(posedge clk); #1;
    start = 1'b1;
    CHANNEL_SIZE = 9'(ch);
    IMAGE_SIZE = 8'(img);
    @(negedge clk);
    checkOutput("zero_rd_en", 256'({kernel_rd_en, pixel_rd_en}), 256'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("zero_done", 256'(done), 256'd1);
    checkOutput("zero_busy", 256'(busy), 256'd0);
    checkOutput("zero_tvalid", 256'(m_axis_tvalid), 256'd0);
    @(negedge clk);
    checkOutput("zero_done_cleared", 256'(done), 256'd0);
    checkOutput("zero_rd_en_after", 256'({kernel_rd_en, pixel_rd_en}), 256'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tvalid"}, 256'(m_axis_tvalid), 256'd0);
    checkOutput({tag, "_tlast"}, 256'(m_axis_tlast), 256'd0);
    checkOutput({tag, "_tdata"}, m_axis_tdata, 256'd0);
    checkOutput({tag, "_rd_en"}, 256'({kernel_rd_en, pixel_rd_en}), 256'd0);
    checkOutput({tag, "_addrs"}, 256'({kernel_addr, pixel_addr}), 256'd0);
    checkOutput({tag, "_flags"}, 256'({busy, done, slave_select}), 256'd0);
  endtask

  initial begin
    int hs, cyc;
    bit hit;
    Reset = 1'b1;
    start = 1'b0;
    CHANNEL_SIZE = '0;
    IMAGE_SIZE = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    Reset = 1'b0;

    $display("[TB] nominal 2x3x3, tready high");
    applyStimulus(2, 3, 0, 0, 1'b0);
    $display("[TB] random tready with start while busy");
    applyStimulus(2, 3, 1, 0, 1'b1);
    $display("[TB] tready low for 10 cycles");
    applyStimulus(2, 3, 0, 10, 1'b0);
    $display("[TB] zero-size starts");
    zeroCase(0, 3);
    zeroCase(2, 0);

    $display("[TB] reset during pixel beat 7");
    @(posedge clk); #1;
    start = 1'b1;
    CHANNEL_SIZE = 9'd2;
    IMAGE_SIZE = 8'd3;
    m_axis_tready = 1'b1;
    hs = 0; cyc = 0; hit = 1'b0;
    while (!hit && cyc < 100) begin
      @(negedge clk);
      if (m_axis_tvalid && hs == 8) begin
        Reset = 1'b1;
        hit = 1'b1;
        #1;
        checkAllZero("midreset");
      end else begin
        if (m_axis_tvalid && m_axis_tready) hs++;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    checkOutput("midreset_reached", 256'(hit), 256'd1);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    applyStimulus(1, 1, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
